// File: rtl/tagged_flux_fifo.sv
// tagged_flux_fifo: one independent circular queue per flux (tagged data
// stream). Writes are steered by the tag field of din into queue[tag].
// Reads use a one-hot strobe and see the selected head word show-ahead on
// dout, re-tagged with its flux index. Sticky flags record overflow and
// underflow attempts until reset.
module tagged_flux_fifo #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] din,
    output logic [FLUX-1:0]  full,
    input  logic [FLUX-1:0]  read,
    output logic [WIDTH-1:0] dout,
    output logic [FLUX-1:0]  empty,
    output logic             err_ovf,
    output logic             err_udf
);

    // Address bits select a slot; the extra top bit is the wrap flag that
    // tells a full queue apart from an empty one when the addresses match.
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [TAG_WIDTH:0] FLUX_L = (TAG_WIDTH + 1)'(FLUX);
    localparam logic [FLUX-1:0]    ONE_L  = FLUX'(1);

    logic [PTR_W-1:0]      wptr_q [FLUX];
    logic [PTR_W-1:0]      wptr_d [FLUX];
    logic [PTR_W-1:0]      rptr_q [FLUX];
    logic [PTR_W-1:0]      rptr_d [FLUX];
    logic [DATA_WIDTH-1:0] mem_q  [FLUX][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [FLUX][DEPTH];
    logic                  err_ovf_q;
    logic                  err_ovf_d;
    logic                  err_udf_q;
    logic                  err_udf_d;

    logic [TAG_WIDTH-1:0]  wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  tag_ok;
    logic [FLUX-1:0]       wr_en;
    logic                  rd_any;
    logic                  rd_onehot;
    logic [FLUX-1:0]       rd_en;
    logic [TAG_WIDTH-1:0]  sel;
    logic                  sel_empty;
    logic [DATA_WIDTH-1:0] sel_head;

    assign wr_tag  = din[WIDTH-1:DATA_WIDTH];
    assign wr_data = din[DATA_WIDTH-1:0];
    assign tag_ok  = {1'b0, wr_tag} < FLUX_L;

    assign rd_any    = |read;
    assign rd_onehot = rd_any && ((read & (read - ONE_L)) == '0);

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

    // Status flags come from registered pointers only, so write/read never
    // reach full/empty combinationally.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < FLUX; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][ADDR_W-1:0] == rptr_q[i][ADDR_W-1:0]) &&
                       (wptr_q[i][PTR_W-1] != rptr_q[i][PTR_W-1]);
        end
    end

    // Per-flux push/pop enables: a push needs a legal tag and room, a pop
    // needs a one-hot strobe and a non-empty queue.
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int i = 0; i < FLUX; i++) begin
            wr_en[i] = write && tag_ok && (wr_tag == TAG_WIDTH'(i)) && !full[i];
            rd_en[i] = rd_onehot && read[i] && !empty[i];
        end
    end

    // Next-state: store and advance pointers per flux; any strobe that did
    // not result in a transfer latches the matching sticky error.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int i = 0; i < FLUX; i++) begin
            if (wr_en[i]) begin
                mem_d[i][wptr_q[i][ADDR_W-1:0]] = wr_data;
                wptr_d[i] = wptr_q[i] + PTR_W'(1);
            end
            if (rd_en[i]) begin
                rptr_d[i] = rptr_q[i] + PTR_W'(1);
            end
        end
        err_ovf_d = err_ovf_q | (write & ~(|wr_en));
        err_udf_d = err_udf_q | (rd_any & ~(|rd_en));
    end

    // Show-ahead output: a one-hot strobe picks its own flux, otherwise the
    // lowest non-empty flux is presented; an empty selection shows zero.
    always_comb begin
        sel       = '0;
        sel_empty = 1'b1;
        sel_head  = '0;
        if (rd_onehot) begin
            for (int i = 0; i < FLUX; i++) begin
                if (read[i]) begin
                    sel = TAG_WIDTH'(i);
                end
            end
        end else begin
            for (int i = FLUX - 1; i >= 0; i--) begin
                if (!empty[i]) begin
                    sel = TAG_WIDTH'(i);
                end
            end
        end
        for (int i = 0; i < FLUX; i++) begin
            if (sel == TAG_WIDTH'(i)) begin
                sel_empty = empty[i];
                sel_head  = mem_q[i][rptr_q[i][ADDR_W-1:0]];
            end
        end
        dout = sel_empty ? '0 : {sel, sel_head};
    end

    // State registers; reset clears pointers, storage and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_q     <= mem_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Testbench for tagged_flux_fifo (FLUX=2, DATA_WIDTH=8, DEPTH=4).
// A count/head model of each queue tracks expected contents and sticky
// flags; a negedge process compares every output against it each cycle,
// while directed sequences pin the model with literal expectations.
module tb_tagged_flux_fifo;

    logic       clk;
    logic       rst;
    logic       write;
    logic [8:0] din;
    logic [1:0] full;
    logic [1:0] read;
    logic [8:0] dout;
    logic [1:0] empty;
    logic       err_ovf;
    logic       err_udf;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    // Reference model: per flux a ring of 4 words with head index and count.
    logic [7:0] mdata [2][4];
    int         mhead [2];
    int         mcnt  [2];
    int         pre   [2];
    bit         movf;
    bit         mudf;
    int         ms;
    int         mt;

    tagged_flux_fifo #(
        .FLUX(2), .DATA_WIDTH(8), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .din(din), .full(full),
        .read(read), .dout(dout), .empty(empty),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model update on each edge, cleared immediately by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mhead[i] = 0;
                mcnt[i]  = 0;
            end
            movf = 0;
            mudf = 0;
        end else begin
            pre[0] = mcnt[0];
            pre[1] = mcnt[1];
            if (read != 2'b00) begin
                if (read == 2'b01 || read == 2'b10) begin
                    ms = read[1] ? 1 : 0;
                    if (pre[ms] > 0) begin
                        mhead[ms] = (mhead[ms] + 1) % 4;
                        mcnt[ms]  = mcnt[ms] - 1;
                    end else begin
                        mudf = 1;
                    end
                end else begin
                    mudf = 1;
                end
            end
            if (write) begin
                mt = din[8] ? 1 : 0;
                if (pre[mt] < 4) begin
                    mdata[mt][(mhead[mt] + mcnt[mt]) % 4] = din[7:0];
                    mcnt[mt] = mcnt[mt] + 1;
                end else begin
                    movf = 1;
                end
            end
        end
    end

    function automatic logic [8:0] expDout(input logic [1:0] rd);
        int s;
        if (rd == 2'b01)      s = 0;
        else if (rd == 2'b10) s = 1;
        else                  s = (mcnt[0] > 0) ? 0 : 1;
        if (mcnt[s] == 0) return 9'h000;
        return {(s == 1), mdata[s][mhead[s]]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_full", 32'(full),
                        32'({mcnt[1] == 4, mcnt[0] == 4}));
            checkOutput("model_empty", 32'(empty),
                        32'({mcnt[1] == 0, mcnt[0] == 0}));
            checkOutput("model_dout", 32'(dout), 32'(expDout(read)));
            checkOutput("model_err_ovf", 32'(err_ovf), 32'(movf));
            checkOutput("model_err_udf", 32'(err_udf), 32'(mudf));
        end
    end

    task automatic applyStimulus(input logic w, input logic [8:0] d,
                                 input logic [1:0] r);
        write = w;
        din   = d;
        read  = r;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst   = 1;
        write = 0;
        din   = 0;
        read  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 0;
        checkEn = 1;
    endtask

    initial begin
        int r;
        write = 0;
        din   = 0;
        read  = 0;
        rst   = 0;
        #2;

        // Reset then idle
        doReset();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("rst_empty", 32'(empty), 32'h3);
        checkOutput("rst_full", 32'(full), 32'h0);
        checkOutput("rst_dout", 32'(dout), 32'h0);
        checkOutput("rst_errs", 32'({err_ovf, err_udf}), 32'h0);

        // Mid-stream reset with 3 words queued in flux 0
        tick();
        applyStimulus(1, 9'h001, 2'b00); tick();
        applyStimulus(1, 9'h002, 2'b00); tick();
        applyStimulus(1, 9'h003, 2'b00); tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("pre_rst_dout", 32'(dout), 32'h001);
        rst = 1;
        #1;
        checkOutput("mid_rst_empty", 32'(empty), 32'h3);
        checkOutput("mid_rst_dout", 32'(dout), 32'h0);
        tick();
        rst = 0;

        // Fill then drain flux 1
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, {1'b1, 8'(8'h10 + k)}, 2'b00);
            tick();
        end
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("fill_full", 32'(full), 32'h2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 9'h000, 2'b10);
            checkOutput("drain_dout", 32'(dout), 32'(9'h110 + k));
            tick();
        end
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("drain_empty", 32'(empty), 32'h3);

        // Wrap-around on flux 0 with simultaneous write and read
        applyStimulus(1, 9'h0A0, 2'b00);
        tick();
        for (int k = 1; k < 6; k++) begin
            applyStimulus(1, {1'b0, 8'(8'hA0 + k)}, 2'b01);
            checkOutput("wrap_dout", 32'(dout), 32'(9'h0A0 + k - 1));
            checkOutput("wrap_full", 32'(full), 32'h0);
            tick();
        end
        applyStimulus(0, 9'h000, 2'b01);
        checkOutput("wrap_last", 32'(dout), 32'h0A5);
        tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("wrap_empty", 32'(empty), 32'h3);
        checkOutput("wrap_errs", 32'({err_ovf, err_udf}), 32'h0);

        // Interleaved fluxes
        applyStimulus(1, 9'h055, 2'b00); tick();
        applyStimulus(1, 9'h1AA, 2'b00); tick();
        applyStimulus(1, 9'h056, 2'b00); tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("intl_idle", 32'(dout), 32'h055);
        applyStimulus(0, 9'h000, 2'b10);
        checkOutput("intl_rd1", 32'(dout), 32'h1AA);
        tick();
        applyStimulus(0, 9'h000, 2'b01);
        checkOutput("intl_rd0a", 32'(dout), 32'h055);
        tick();
        applyStimulus(0, 9'h000, 2'b01);
        checkOutput("intl_rd0b", 32'(dout), 32'h056);
        tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("intl_empty", 32'(empty), 32'h3);

        // Write plus read on a full flux 0
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, {1'b0, 8'(8'h70 + k)}, 2'b00);
            tick();
        end
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("f0_full", 32'(full), 32'h1);
        applyStimulus(1, 9'h077, 2'b01);
        checkOutput("f0_pop_dout", 32'(dout), 32'h070);
        tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("f0_ovf", 32'(err_ovf), 32'h1);
        checkOutput("f0_udf", 32'(err_udf), 32'h0);
        checkOutput("f0_notfull", 32'(full), 32'h0);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 9'h000, 2'b01);
            checkOutput("f0_rest", 32'(dout), 32'(9'h070 + k));
            tick();
        end
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("f0_count3", 32'(empty), 32'h3);

        // Underflow and non-one-hot reads
        doReset();
        applyStimulus(0, 9'h000, 2'b01);
        checkOutput("udf_dout", 32'(dout), 32'h0);
        tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("udf_flag", 32'(err_udf), 32'h1);
        checkOutput("udf_ovf", 32'(err_ovf), 32'h0);
        checkOutput("udf_empty", 32'(empty), 32'h3);
        applyStimulus(1, 9'h011, 2'b00); tick();
        applyStimulus(1, 9'h122, 2'b00); tick();
        applyStimulus(0, 9'h000, 2'b11);
        checkOutput("both_dout", 32'(dout), 32'h011);
        tick();
        applyStimulus(0, 9'h000, 2'b00);
        checkOutput("both_nopop", 32'(empty), 32'h0);
        checkOutput("both_head0", 32'(dout), 32'h011);
        applyStimulus(0, 9'h000, 2'b10);
        checkOutput("both_head1", 32'(dout), 32'h122);
        tick();

        // Randomized traffic checked by the model every cycle
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                doReset();
            end
            r = $urandom_range(0, 9);
            applyStimulus(($urandom_range(0, 9) < 6),
                          9'($urandom_range(0, 511)),
                          (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11);
            tick();
        end
        applyStimulus(0, 9'h000, 2'b00);
        @(negedge clk);
        #1;
        checkEn = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
